// File: rtl/acc_ctrl_pkg.sv
// Shared types and constants for the accumulator command sequencer.
// Opcode and state encodings live here so the bench and RTL agree on them.
package acc_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        CMD_LOAD  = 2'd0,
        CMD_ADD   = 2'd1,
        CMD_CLEAR = 2'd2,
        CMD_READ  = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        CLEAR = 2'd2,
        READ  = 2'd3
    } state_e;

endpackage

// File: rtl/acc_ctrl_if.sv
// Command, readout and accumulator-side signals of acc_ctrl bundled together.
// The slave modport is the sequencer; the master modport is the pad/accumulator side.
interface acc_ctrl_if #(
    parameter int ACC_WIDTH = 64
);
    import acc_ctrl_pkg::*;

    logic                 cmd_valid;
    cmd_e                 cmd;
    logic [BYTE_W-1:0]    data_in;
    logic                 cmd_ready;

    logic [ACC_WIDTH-1:0] acc_add_value;
    logic                 acc_clr_n;
    logic [ACC_WIDTH-1:0] acc_value;

    logic                 out_valid;
    logic [BYTE_W-1:0]    out_data;
    logic                 out_last;
    logic                 out_ready;

    modport master (
        output cmd_valid,
        output cmd,
        output data_in,
        input  cmd_ready,
        input  acc_add_value,
        input  acc_clr_n,
        output acc_value,
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        input  data_in,
        output cmd_ready,
        output acc_add_value,
        output acc_clr_n,
        input  acc_value,
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

endinterface

// File: rtl/acc_byte_ser.sv
// Parallel-load readout register that streams a word out MSB byte first
// over a valid/ready/last handshake; done pulses on the final handshake.
module acc_byte_ser
    import acc_ctrl_pkg::*;
#(
    parameter int ACC_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [ACC_WIDTH-1:0] load_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [BYTE_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 done
);

    localparam int NBYTES = ACC_WIDTH / BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    logic [ACC_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     count;
    logic                 valid;
    logic                 fire;

    assign fire = valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            count <= '0;
            valid <= 1'b0;
        end else if (load) begin
            shreg <= load_data;
            count <= CNT_W'(NBYTES);
            valid <= 1'b1;
        end else if (fire) begin
            shreg <= shreg << BYTE_W;
            count <= count - 1'b1;
            if (count == CNT_W'(1)) begin
                valid <= 1'b0;
            end
        end
    end

    // All outputs decode straight from the register state, so a stall holds them.
    assign out_valid = valid;
    assign out_data  = shreg[ACC_WIDTH-1 -: BYTE_W];
    assign out_last  = valid && (count == CNT_W'(1));
    assign done      = fire && out_last;

endmodule

// File: rtl/acc_ctrl.sv
// Command sequencer for the accumulator: byte-wise operand load, counted add
// bursts, one-cycle clear and a byte-serial readout of a snapshot.
module acc_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int ACC_WIDTH = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    acc_ctrl_if.slave bus
);

    state_e               state;
    state_e               state_next;
    logic [ACC_WIDTH-1:0] operand;
    logic [BYTE_W-1:0]    remaining;
    logic                 accept;
    logic                 load_ser;
    logic                 ser_done;

    assign accept = bus.cmd_valid && bus.cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            operand   <= '0;
            remaining <= '0;
        end else begin
            state <= state_next;
            if (accept && bus.cmd == CMD_LOAD) begin
                operand <= {operand[ACC_WIDTH-BYTE_W-1:0], bus.data_in};
            end
            if (accept && bus.cmd == CMD_ADD) begin
                remaining <= bus.data_in;
            end else if (state == ADD) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        load_ser   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd)
                        CMD_ADD: begin
                            if (bus.data_in != '0) begin
                                state_next = ADD;
                            end
                        end
                        CMD_CLEAR: state_next = CLEAR;
                        CMD_READ: begin
                            state_next = READ;
                            load_ser   = 1'b1;
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
            ADD: begin
                if (remaining == 8'd1) begin
                    state_next = IDLE;
                end
            end
            CLEAR:   state_next = IDLE;
            READ: begin
                if (ser_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode only from registered state; the addend is gated to zero outside ADD.
    assign bus.cmd_ready     = (state == IDLE);
    assign bus.acc_add_value = (state == ADD) ? operand : '0;
    assign bus.acc_clr_n     = (state != CLEAR);

    acc_byte_ser #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_ser),
        .load_data (bus.acc_value),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_acc_ctrl.sv
// Directed bench for acc_ctrl with a behavioural accumulator hooked to its
// addend/clear outputs; expected values are hand-computed constants.
module tb_acc_ctrl;
    import acc_ctrl_pkg::*;

    localparam int ACC_WIDTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checkCount = 0;
    int   passCount  = 0;

    logic [ACC_WIDTH-1:0] accReg;
    logic                 accForce    = 1'b0;
    logic [ACC_WIDTH-1:0] accForceVal = '0;

    acc_ctrl_if #(.ACC_WIDTH(ACC_WIDTH)) bus();

    acc_ctrl #(.ACC_WIDTH(ACC_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n || !bus.acc_clr_n) accReg <= '0;
        else                          accReg <= accReg + bus.acc_add_value;
    end

    assign bus.acc_value = accForce ? accForceVal : accReg;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input cmd_e op, input logic [7:0] arg);
        bus.cmd_valid = 1'b1;
        bus.cmd       = op;
        bus.data_in   = arg;
        tick();
        bus.cmd_valid = 1'b0;
        bus.data_in   = 8'h00;
    endtask

    task automatic loadOperand(input logic [63:0] value);
        for (int i = 7; i >= 0; i--) applyStimulus(CMD_LOAD, value[i*8 +: 8]);
    endtask

    task automatic runAdd(input logic [7:0] n, input logic [63:0] expAddend, input string tag);
        int          busy      = 0;
        int          addCycles = 0;
        logic [63:0] seen      = '0;
        applyStimulus(CMD_ADD, n);
        while (!bus.cmd_ready && busy < 300) begin
            if (bus.acc_add_value != '0) begin
                addCycles++;
                seen = bus.acc_add_value;
            end
            busy++;
            tick();
        end
        checkOutput({tag, "_cycles"}, 64'(addCycles), 64'(n));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(n));
        checkOutput({tag, "_addend"}, seen, (n == 8'd0) ? 64'd0 : expAddend);
    endtask

    task automatic runRead(input logic [63:0] expected, input bit randomReady, input bit forceMid,
                           input string tag);
        logic [63:0] got    = '0;
        int          nBytes = 0;
        int          cycles = 0;
        logic [7:0]  held;
        bit          stalled;
        applyStimulus(CMD_READ, 8'h00);
        checkOutput({tag, "_valid_t1"}, 64'(bus.out_valid), 64'd1);
        while (nBytes < 8 && cycles < 200) begin
            bus.out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (forceMid && nBytes == 3) begin
                accForce    = 1'b1;
                accForceVal = 64'h0123_4567_89AB_CDEF;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                got = {got[55:0], bus.out_data};
                checkOutput($sformatf("%s_last%0d", tag, nBytes), 64'(bus.out_last), 64'(nBytes == 7));
                nBytes++;
            end
            cycles++;
            tick();
            if (stalled) checkOutput({tag, "_hold"}, 64'(bus.out_data), 64'(held));
        end
        bus.out_ready = 1'b0;
        accForce      = 1'b0;
        checkOutput({tag, "_bytes"}, 64'(nBytes), 64'd8);
        checkOutput({tag, "_data"}, got, expected);
        checkOutput({tag, "_ready_after"}, 64'(bus.cmd_ready), 64'd1);
        checkOutput({tag, "_valid_after"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        checkOutput({tag, "_add_value"}, bus.acc_add_value, 64'd0);
        checkOutput({tag, "_clr_n"}, 64'(bus.acc_clr_n), 64'd1);
        checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
        checkOutput({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nonZero;
        bus.cmd_valid = 1'b0;
        bus.cmd       = CMD_LOAD;
        bus.data_in   = 8'h00;
        bus.out_ready = 1'b0;

        rst_n = 1'b0;
        tick();
        tick();
        checkResetOutputs("rst");
        rst_n = 1'b1;
        tick();

        loadOperand(64'h0102_0304_0506_0708);
        checkOutput("load_ready", 64'(bus.cmd_ready), 64'd1);
        runAdd(8'd1, 64'h0102_0304_0506_0708, "add1");
        runRead(64'h0102_0304_0506_0708, 1'b0, 1'b0, "read1");

        applyStimulus(CMD_CLEAR, 8'h00);
        tick();
        loadOperand(64'h10);
        runAdd(8'd255, 64'h10, "burst");
        runRead(64'h0000_0000_0000_0FF0, 1'b0, 1'b0, "read_burst");

        runAdd(8'd0, 64'h10, "add0");

        // A command offered while CLEAR is in flight must be dropped.
        applyStimulus(CMD_CLEAR, 8'h00);
        checkOutput("clr_low", 64'(bus.acc_clr_n), 64'd0);
        checkOutput("clr_busy", 64'(bus.cmd_ready), 64'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd       = CMD_ADD;
        bus.data_in   = 8'd5;
        tick();
        bus.cmd_valid = 1'b0;
        bus.data_in   = 8'h00;
        checkOutput("clr_high", 64'(bus.acc_clr_n), 64'd1);
        checkOutput("clr_ready", 64'(bus.cmd_ready), 64'd1);
        checkOutput("ignored_add", bus.acc_add_value, 64'd0);
        tick();
        checkOutput("ignored_add_late", bus.acc_add_value, 64'd0);
        runRead(64'd0, 1'b0, 1'b0, "read_clear");

        loadOperand(64'hFFFF_FFFF_FFFF_FFFF);
        runAdd(8'd2, 64'hFFFF_FFFF_FFFF_FFFF, "wrap");
        runRead(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, "read_wrap");

        // Reset lands on the third cycle of a 200-cycle burst.
        applyStimulus(CMD_ADD, 8'd200);
        checkOutput("rst_burst_c1", bus.acc_add_value, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checkResetOutputs("rst_mid_add");
        rst_n   = 1'b1;
        nonZero = 0;
        for (int i = 0; i < 250; i++) begin
            if (bus.acc_add_value != '0) nonZero++;
            tick();
        end
        checkOutput("rst_no_addend", 64'(nonZero), 64'd0);

        loadOperand(64'hA1B2_C3D4_E5F6_0718);
        runAdd(8'd1, 64'hA1B2_C3D4_E5F6_0718, "pre_rst_read");
        bus.out_ready = 1'b0;
        applyStimulus(CMD_READ, 8'h00);
        checkOutput("rst_read_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("rst_read_byte0", 64'(bus.out_data), 64'hA1);
        rst_n = 1'b0;
        tick();
        checkResetOutputs("rst_mid_read");
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/acc_ctrl.md
# acc_ctrl

Command sequencer for the 64-bit accumulator datapath. Accepts byte-wide commands from the chip inputs: builds the addend operand byte by byte, issues a counted burst of adds, clears the accumulator, and streams the accumulator value back out as bytes. It sits between the pad-level inputs/outputs in the top and the accumulator instance. The accumulator itself adds its addend input every cycle, so this block gates that addend to zero whenever no add is scheduled.

## Interface
Parameters:
- ACC_WIDTH, 64: accumulator and operand width; must be a multiple of 8.
- NBYTES, ACC_WIDTH/8: bytes per operand load and per readout (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- cmd_valid  in  1  command strobe.
- cmd  in  2  opcode: 0 LOAD, 1 ADD, 2 CLEAR, 3 READ.
- data_in  in  8  command argument.
- cmd_ready  out  1  high only in IDLE.
- acc_add_value  out  ACC_WIDTH  addend to the accumulator; zero unless adding.
- acc_clr_n  out  1  active-low accumulator clear; the top ANDs it with rst_n.
- acc_value  in  ACC_WIDTH  current accumulator register value.
- out_valid  out  1  readout byte valid.
- out_data  out  8  readout byte, MSB byte first.
- out_last  out  1  marks the final readout byte.
- out_ready  in  1  readout consumer ready.

## Operation
States: IDLE, ADD, CLEAR, READ. A command is accepted on cmd_valid && cmd_ready.

- **LOAD** (in IDLE):
  - operand <= {operand[ACC_WIDTH-9:0], data_in}.
  - State stays IDLE. A full operand takes NBYTES LOADs, MSB byte first.
  - The operand register persists across ADD, CLEAR and READ; only reset zeroes it.
- **ADD**:
  - remaining <= data_in.
  - If data_in == 0: no-op, stay IDLE.
  - Else go to ADD. acc_add_value = operand for exactly data_in consecutive cycles, with remaining decremented each cycle. On the final cycle (remaining == 1), go to IDLE.
- **CLEAR**: go to CLEAR. acc_clr_n = 0 for exactly one cycle, then IDLE.
- **READ**:
  - Snapshot acc_value into an NBYTES shift register and go to READ.
  - out_valid = 1 and out_data = shift register top byte.
  - On out_valid && out_ready: shift left by 8 and decrement the byte counter.
  - out_last = 1 while the byte counter indicates the final byte.
  - A handshake with out_last high returns to IDLE.
  - out_data must hold stable while out_valid && !out_ready.
- Accumulator arithmetic wraps modulo 2^ACC_WIDTH. The block does not detect overflow.
- Commands presented while cmd_ready = 0 are ignored, not queued.

## Timing
- All outputs are registered.
- Reset values: cmd_ready = 1 (IDLE), acc_add_value = 0, acc_clr_n = 1, out_valid = 0, out_last = 0, out_data = 0. Operand, shift register and counters are 0.
- Command accepted in cycle T:
  - ADD: acc_add_value is non-zero during T+1 .. T+N, and cmd_ready rises at T+N+1. The accumulator reflects +N·operand at T+N+1.
  - CLEAR: acc_clr_n is low during T+1, the accumulator reads 0 at T+2, and cmd_ready rises at T+2.
  - READ: out_valid rises at T+1. With out_ready held high, 8 bytes arrive on T+1 .. T+8 and cmd_ready rises at T+9.
  - LOAD: cmd_ready stays high, so back-to-back LOADs are allowed every cycle.
- The READ snapshot is taken from acc_value in the accept cycle. Later accumulator changes do not affect the stream in progress.
- rst_n low in any state, mid-burst or mid-readout:
  - Next edge returns to IDLE with the reset values above.
  - Any in-progress add burst is abandoned; no further addends are issued.
  - A partial readout is dropped.
- out_ready high outside READ has no effect.

## Structure
- Package acc_ctrl_pkg holds:
  - cmd_e opcode encodings (CMD_LOAD, CMD_ADD, CMD_CLEAR, CMD_READ).
  - state_e (IDLE, ADD, CLEAR, READ).
  - the BYTE_W = 8 constant.
- One sub-module, acc_byte_ser. It is a parallel-load, byte-shift readout register with the valid/ready/last handshake, parameterised by ACC_WIDTH. The FSM only issues the load strobe and observes done.
- The remaining logic lives in acc_ctrl: FSM, operand shifter and add-burst counter.

## Test plan
- **Load and read:**
  - Reset, then LOAD 8 bytes 01..08, ADD data_in=1, READ with out_ready=1.
  - Expect bytes 01,02,03,04,05,06,07,08, with out_last on the 8th byte only.
- **Burst add:**
  - operand = 0x10, ADD data_in=255.
  - Expect acc_add_value non-zero for exactly 255 cycles, and READ returns 0x0000_0000_0000_0FF0.
- **Boundary cases:**
  - ADD data_in=0: no addend cycle and cmd_ready stays high.
  - Operand 0xFFFF_FFFF_FFFF_FFFF with ADD 2: READ gives 0xFFFF_FFFF_FFFF_FFFE (wrap-around).
- **Clear and ignored command:**
  - CLEAR then READ returns 8 zero bytes, and acc_clr_n is low for exactly 1 cycle.
  - A command issued during CLEAR (cmd_ready = 0) is ignored.
- **Backpressure:**
  - During READ, toggle out_ready with a random pattern.
  - out_data holds while stalled and no byte is lost or duplicated.
  - The snapshot is unaffected by an acc_value change forced mid-stream.
- **Reset mid-operation:**
  - Assert rst_n=0 for one cycle at cycle 3 of a 200-cycle ADD burst.
  - Expect all outputs at their reset values the next cycle and no further non-zero acc_add_value.
